// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states, widths
// and the default shift step.
package shift_sequencer_pkg;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned SHAMT_W      = 5;
   localparam int unsigned OP_W         = 2;
   // Per-cycle shift amount width; covers 0..4, the largest legal STEP.
   localparam int unsigned AMT_W        = 3;
   localparam int unsigned DEFAULT_STEP = 2;

   localparam logic [OP_W-1:0] OP_SLL  = 2'b00;
   localparam logic [OP_W-1:0] OP_SRL  = 2'b01;
   localparam logic [OP_W-1:0] OP_SRA  = 2'b10;
   localparam logic [OP_W-1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: shifts value_i left or right by amt_i
// positions, filling vacated high bits with fill_i on right shifts.
module shift_step
   import shift_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] value_i,
   input  logic              dir_right_i,
   input  logic              fill_i,
   input  logic [AMT_W-1:0]  amt_i,
   output logic [DATA_W-1:0] value_c
);

   // Right shift works on a fill-extended word so the fill bits slide in.
   always_comb begin
      if (dir_right_i) begin
         value_c = DATA_W'({{DATA_W{fill_i}}, value_i} >> amt_i);
      end else begin
         value_c = value_i << amt_i;
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift sequencer: shifts a latched 32-bit operand by up to
// STEP positions per cycle through a single reused shift_step stage.
// Optional feature macro: SHIFT_SRA_EN enables arithmetic right shift (Op=10);
// without it Op=10 is reported as illegal and no sign-fill logic is built.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned STEP = DEFAULT_STEP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [OP_W-1:0]    op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [DATA_W-1:0]  a,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  result
);

   // Reject unsupported step sizes at elaboration.
   if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
      $error("shift_sequencer: STEP must be 1, 2 or 4");
   end

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0]  rem_q, rem_d;
   logic                right_q, right_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                illegal_c;
   logic                fill_c;
   logic [AMT_W-1:0]    amt_c;
   logic [DATA_W-1:0]   shifted_c;

`ifdef SHIFT_SRA_EN
   logic                fill_q, fill_d;
   assign fill_c = fill_q;
`else
   assign fill_c = 1'b0;
`endif

   // Opcode legality of the requesting op.
   always_comb begin
`ifdef SHIFT_SRA_EN
      illegal_c = (op == OP_RSVD);
`else
      illegal_c = (op == OP_RSVD) || (op == OP_SRA);
`endif
   end

   // This cycle's shift amount: min(STEP, remaining).
   always_comb begin
      if (rem_q > SHAMT_W'(STEP)) begin
         amt_c = AMT_W'(STEP);
      end else begin
         amt_c = AMT_W'(rem_q);
      end
   end

   // Single shared shift stage, reused every SHIFT cycle.
   shift_step u_shift_step (
      .value_i     (work_q),
      .dir_right_i (right_q),
      .fill_i      (fill_c),
      .amt_i       (amt_c),
      .value_c     (shifted_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      rem_d    = rem_q;
      right_d  = right_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef SHIFT_SRA_EN
      fill_d   = fill_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d  = a;
               rem_d   = shamt;
               right_d = (op != OP_SLL);
`ifdef SHIFT_SRA_EN
               fill_d  = a[DATA_W-1] && (op == OP_SRA);
`endif
               busy_d  = 1'b1;
               if (shamt == '0 || illegal_c) begin
                  // Nothing to shift: finish immediately with the operand.
                  state_d  = ST_DONE;
                  rem_d    = '0;
                  result_d = a;
                  done_d   = 1'b1;
                  err_d    = illegal_c;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            busy_d = 1'b1;
            work_d = shifted_c;
            rem_d  = rem_q - SHAMT_W'(amt_c);
            if (rem_d == '0) begin
               state_d  = ST_DONE;
               result_d = shifted_c;
               done_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         rem_q    <= '0;
         right_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef SHIFT_SRA_EN
         fill_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         right_q  <= right_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef SHIFT_SRA_EN
         fill_q   <= fill_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shift model.
// Honours SHIFT_SRA_EN to match the DUT build.
module tb_shift_sequencer;

   localparam int unsigned STEP = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   shift_sequencer #(.STEP(STEP)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .shamt  (shamt),
      .a      (a),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic sra_en();
`ifdef SHIFT_SRA_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic model_err(input logic [1:0] o);
      return (o == 2'b11) || (o == 2'b10 && !sra_en());
   endfunction

   function automatic logic [31:0] model_result(input logic [31:0] x, input logic [1:0] o,
                                                input logic [4:0] s);
      if (model_err(o)) return x;
      case (o)
         2'b00:   return x << s;
         2'b01:   return x >> s;
         default: return 32'($signed(x) >>> s);
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [4:0] s);
      if (model_err(o) || s == 5'd0) return 1;
      return (int'(s) + int'(STEP) - 1) / int'(STEP) + 1;
   endfunction

   // Issue one operation; scramble inputs while in flight, optionally pulsing start.
   task automatic do_op(input logic [31:0] a_in, input logic [1:0] op_in, input logic [4:0] sh_in,
                        input logic noise, output int lat, output logic [31:0] res,
                        output logic e, output logic timeout);
      lat = 0; res = '0; e = 1'b0; timeout = 1'b1;
      @(negedge clk);
      a = a_in; op = op_in; shamt = sh_in; start = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k; res = result; e = err; timeout = 1'b0;
            break;
         end
         start = noise ? 1'($urandom) : 1'b0;
         a     = $urandom;
         op    = 2'($urandom);
         shamt = 5'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = '0; shamt = '0; a = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      logic [31:0] va [4];
      logic [1:0]  vo [4];
      logic [4:0]  vs [4];
      logic [31:0] vr [4];
      logic        ve [4];
      int          vl [4];
      int lat; logic [31:0] res; logic e, to;
      va[0] = 32'h0000_0001; vo[0] = 2'b00; vs[0] = 5'd2;  vr[0] = 32'h0000_0004; ve[0] = 1'b0; vl[0] = 2;
      va[1] = 32'h8000_0000; vo[1] = 2'b10; vs[1] = 5'd31;
`ifdef SHIFT_SRA_EN
      vr[1] = 32'hFFFF_FFFF; ve[1] = 1'b0; vl[1] = 17;
`else
      vr[1] = 32'h8000_0000; ve[1] = 1'b1; vl[1] = 1;
`endif
      va[2] = 32'hF000_000F; vo[2] = 2'b01; vs[2] = 5'd0;  vr[2] = 32'hF000_000F; ve[2] = 1'b0; vl[2] = 1;
      va[3] = 32'hDEAD_BEEF; vo[3] = 2'b11; vs[3] = 5'd7;  vr[3] = 32'hDEAD_BEEF; ve[3] = 1'b1; vl[3] = 1;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vo[i], vs[i], 1'b0, lat, res, e, to);
         checks++; if (to) begin failures++; $display("FAIL vec%0d_timeout: no done within 100 cycles", i); end
         checks++; if (lat !== vl[i]) begin failures++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, vl[i]); end
         checks++; if (res !== vr[i]) begin failures++; $display("FAIL vec%0d_result: got %h expected %h", i, res, vr[i]); end
         checks++; if (e !== ve[i]) begin failures++; $display("FAIL vec%0d_err: got %b expected %b", i, e, ve[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat; logic [31:0] res; logic e, to;
      logic [31:0] ra; logic [1:0] ro; logic [4:0] rs; logic [31:0] exp_r;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         ro = 2'($urandom);
         case ($urandom % 4)
            0:       rs = 5'd0;
            1:       rs = 5'd31;
            default: rs = 5'($urandom);
         endcase
         exp_r = model_result(ra, ro, rs);
         do_op(ra, ro, rs, 1'($urandom), lat, res, e, to);
         checks++; if (to) begin failures++; $display("FAIL rnd%0d_timeout: no done within 100 cycles", i); end
         checks++; if (res !== exp_r) begin failures++; $display("FAIL rnd%0d_result: a=%h op=%0d sh=%0d got %h expected %h", i, ra, ro, rs, res, exp_r); end
         checks++; if (e !== model_err(ro)) begin failures++; $display("FAIL rnd%0d_err: got %b expected %b", i, e, model_err(ro)); end
         checks++; if (lat !== model_lat(ro, rs)) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, model_lat(ro, rs)); end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
            failures++;
            $display("FAIL rnd%0d_idle_hold: done=%b busy=%b result=%h expected done=0 busy=0 result=%h", i, done, busy, result, exp_r);
         end
         repeat ($urandom % 3) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      int first = 0;
      @(negedge clk);
      a = 32'h0000_0001; op = 2'b00; shamt = 5'd8; start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (first == 0) first = k;
         end
         if (done) begin
            start = 1'b1;                       // lands on the DONE cycle
         end else if (k <= 3) begin
            start = 1'b1; a = 32'h1234_5678; op = 2'b01; shamt = 5'd3;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checks++; if (dones !== 1) begin failures++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
      checks++; if (first !== 5) begin failures++; $display("FAIL b2b_latency: got %0d expected 5", first); end
      checks++; if (result !== 32'h0000_0100) begin failures++; $display("FAIL b2b_result: got %h expected 00000100", result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_shift();
      int lat; logic [31:0] res; logic e, to;
      int dones = 0;
      int busies = 0;
      do_op(32'h0000_00F0, 2'b01, 5'd4, 1'b0, lat, res, e, to);
      checks++; if (res !== 32'h0000_000F) begin failures++; $display("FAIL pre_reset_result: got %h expected 0000000f", res); end
      @(negedge clk);
      a = 32'hAAAA_5555; op = 2'b00; shamt = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL mid_reset_result: got %h expected 0", result); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_reset_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (busy) busies++;
      end
      checks++; if (dones !== 0 || busies !== 0) begin failures++; $display("FAIL post_reset_quiet: done pulses %0d busy cycles %0d expected 0 and 0", dones, busies); end
      do_op(32'h0000_0003, 2'b00, 5'd1, 1'b0, lat, res, e, to);
      checks++; if (res !== 32'h0000_0006) begin failures++; $display("FAIL fresh_result: got %h expected 00000006", res); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL fresh_latency: got %0d expected 2", lat); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL fresh_err: got %b expected 0", e); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter STEP, default 2: bit positions shifted per SHIFT cycle; legal values are 1, 2 and 4.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  asynchronous reset, active low.
REQ-004 Start  input  1  request strobe; sampled only in IDLE.
REQ-005 Op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-006 Shamt  input  5  shift amount, 0..31.
REQ-007 A  input  32  operand.
REQ-008 Busy  output  1  high in SHIFT and DONE states.
REQ-009 Done  output  1  single-cycle completion pulse.
REQ-010 Err  output  1  high with Done when the operation was illegal.
REQ-011 Result  output  32  shifted value; valid from Done until the next accepted Start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with Start=1 SHALL latch A, Op and Shamt into internal registers (Remaining := Shamt) and go to SHIFT; if Shamt=0 or Op is illegal, it SHALL go directly to DONE.
REQ-014 In SHIFT, each cycle SHALL shift the working register by min(STEP, Remaining) positions and decrement Remaining by the same amount.
REQ-015 SHIFT SHALL go to DONE in the cycle that Remaining reaches 0.
REQ-016 SLL and SRL SHALL zero-fill; SRA SHALL replicate bit 31 of the latched operand; all arithmetic is 32-bit and bits shifted out are discarded.
REQ-017 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-018 Latency from the Start-accept edge to Done SHALL be ceil(Shamt/STEP)+1 cycles; for Shamt=0 it SHALL be 1 cycle.
REQ-019 Start while Busy=1 SHALL be ignored and SHALL NOT alter the latched operands.
REQ-020 Start in the same cycle as DONE SHALL be ignored; Start is accepted only in IDLE.
REQ-021 A, Op and Shamt changing after acceptance SHALL NOT affect the operation in flight.
REQ-022 An illegal Op SHALL give Result=A unchanged, Err=1 and Done=1.
REQ-023 Result SHALL hold its value in IDLE until the next accepted Start.

Reset
REQ-024 Rst_n=0 SHALL force IDLE immediately, asynchronously, regardless of Clk.
REQ-025 On reset: Busy=0, Done=0, Err=0, Result=32'h0, Remaining=0.
REQ-026 Reset during SHIFT SHALL abort the operation with no Done pulse.
REQ-027 The first Start accepted after reset deassertion SHALL behave as a fresh operation.

Configuration
REQ-028 With SHIFT_SRA_EN defined, Op=10 SHALL perform an arithmetic right shift.
REQ-029 Without SHIFT_SRA_EN, Op=10 SHALL be treated as illegal per REQ-022, and the sign-fill logic SHALL be absent.

Structure
REQ-030 The shared package SHALL hold the Op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSVD), the FSM state enum and the default STEP.
REQ-031 A combinational sub-module shift_step (32-bit value, direction, fill bit, amount 0..STEP in, 32-bit value out) SHALL implement one shift stage.
REQ-032 The sequencer SHALL instantiate shift_step exactly once, reusing it in every SHIFT cycle.

Verification
REQ-033 A=32'h0000_0001, Op=SLL, Shamt=2, STEP=2 -> Done 2 cycles after accept, Result=32'h0000_0004, Err=0.
REQ-034 A=32'h8000_0000, Op=SRA, Shamt=31, with SHIFT_SRA_EN -> Result=32'hFFFF_FFFF after 17 cycles; without the macro -> Result=32'h8000_0000, Err=1, 1 cycle.
REQ-035 A=32'hF000_000F, Op=SRL, Shamt=0 -> Done the next cycle, Result=32'hF000_000F.
REQ-036 Start re-pulsed with A=32'h1234_5678 during a 5-cycle SLL of 32'h1 by 8 -> Result=32'h0000_0100 and only one Done pulse.
REQ-037 Rst_n pulsed low mid-SHIFT -> Busy=0 and Result=0 immediately, no Done; the next SLL of 32'h3 by 1 -> 32'h6.
REQ-038 Op=11, A=32'hDEAD_BEEF -> Result=32'hDEAD_BEEF, Err=1 and Done=1 one cycle after accept.
